// File: rtl/alu_acc_sequencer.sv
// alu_acc_sequencer: command-driven accumulator stage feeding an external ALU, with repeat and result handshake
module alu_acc_sequencer #(
    parameter int WIDTH = 8,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [2:0]       cmd_oper,
    input  logic [WIDTH-1:0] cmd_operand,
    input  logic             cmd_use_cy,
    input  logic [REP_W-1:0] cmd_repeat,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_oper,
    output logic             alu_c_in,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_c_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [REP_W-1:0]   count_q, count_d;
    logic [2:0]         oper_q, oper_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic               use_cy_q, use_cy_d;
    logic               load_q, load_d;

    assign cmd_ready = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign alu_a     = acc_q;
    assign alu_b     = operand_q;
    assign alu_oper  = oper_q;
    assign alu_c_in  = use_cy_q & carry_q;
    assign res_data  = acc_q;
    assign res_carry = carry_q;
    assign res_zero  = (acc_q == '0);

    // state and datapath registers; reset aborts any command in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            count_q   <= '0;
            oper_q    <= '0;
            operand_q <= '0;
            use_cy_q  <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            count_q   <= count_d;
            oper_q    <= oper_d;
            operand_q <= operand_d;
            use_cy_q  <= use_cy_d;
            load_q    <= load_d;
        end
    end

    // next-state: latch command in IDLE, iterate ALU in EXEC, hold result in DONE
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        count_d   = count_q;
        oper_d    = oper_q;
        operand_d = operand_q;
        use_cy_d  = use_cy_q;
        load_d    = load_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    oper_d    = cmd_oper;
                    operand_d = cmd_operand;
                    use_cy_d  = cmd_use_cy;
                    load_d    = cmd_load;
                    count_d   = cmd_repeat;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                acc_d   = load_q ? operand_q : alu_sum;
                carry_d = load_q ? 1'b0 : alu_c_out;
                if (load_q || count_q == '0) begin
                    count_d = '0;
                    state_d = DONE;
                end else begin
                    count_d = count_q - REP_W'(1);
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
